// File: rtl/vmips_alu_pkg.sv
// Shared definitions for the element-serial vector ALU: op codes, data formats,
// FSM state encoding and format helpers.
// Build option: VEC_ALU_SATURATE_EN selects saturating ADD/SUB in vec_elem_alu.
package vmips_alu_pkg;

    localparam int VEC_W = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOR  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] DF_B   = 2'b00;
    localparam logic [1:0] DF_H   = 2'b01;
    localparam logic [1:0] DF_W   = 2'b10;
    localparam logic [1:0] DF_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Number of elements in a vector for a given data format (0 for reserved).
    function automatic logic [2:0] n_elem(input logic [1:0] df);
        case (df)
            DF_B:    n_elem = 3'd4;
            DF_H:    n_elem = 3'd2;
            DF_W:    n_elem = 3'd1;
            default: n_elem = 3'd0;
        endcase
    endfunction

    // Low-aligned bit mask covering one element of the given format.
    function automatic logic [VEC_W-1:0] elem_mask(input logic [1:0] df);
        case (df)
            DF_B:    elem_mask = VEC_W'(32'h0000_00FF);
            DF_H:    elem_mask = VEC_W'(32'h0000_FFFF);
            default: elem_mask = '1;
        endcase
    endfunction

endpackage

// File: rtl/vec_elem_alu.sv
// Single-element ALU: computes one byte/half/word element result and its signed overflow.
// Latency: purely combinational. Backpressure: none, no state.
// Build option: VEC_ALU_SATURATE_EN clamps overflowing ADD/SUB to the signed range.
module vec_elem_alu
    import vmips_alu_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic [2:0]   op,
    input  logic [1:0]   w,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam int SBW = $clog2(W);

    logic [W-1:0]   mask;
    logic [SBW-1:0] sbit;
    logic [W-1:0]   am, bm, as_x, bs_x, sum, diff;
    logic           sa, sb;

    // Element operation: operands are masked to the element width, sign bit sits at w-1.
    always_comb begin
        mask = W'(elem_mask(w));
        case (w)
            DF_B:    sbit = SBW'(7);
            DF_H:    sbit = SBW'(15);
            default: sbit = SBW'(W - 1);
        endcase
        am   = a & mask;
        bm   = b & mask;
        sa   = am[sbit];
        sb   = bm[sbit];
        as_x = am | (sa ? ~mask : '0);
        bs_x = bm | (sb ? ~mask : '0);
        sum  = (am + bm) & mask;
        diff = (am - bm) & mask;
        y    = '0;
        ovf  = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (sa == sb) && (sum[sbit] != sa);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (sa != sb) && (diff[sbit] != sa);
            end
            ALU_AND:  y = am & bm;
            ALU_OR:   y = am | bm;
            ALU_SLT:  y = W'($signed(as_x) < $signed(bs_x));
            ALU_XOR:  y = am ^ bm;
            ALU_NOR:  y = ~(am | bm) & mask;
            default:  y = W'(am < bm);
        endcase
`ifdef VEC_ALU_SATURATE_EN
        // Overflow only arises for ADD/SUB; clamp toward the sign of A.
        if (ovf) begin
            y = sa ? (mask & ~(mask >> 1)) : (mask >> 1);
        end
`endif
    end

endmodule

// File: rtl/vec_alu_seq.sv
// Element-serial SIMD ALU: one request in, one element per cycle, vector result + flags out.
// Latency: byte 4, half 2, word 1 cycles from accept to out_valid; reserved df goes straight to DONE.
// Backpressure: result held in DONE until out_ready; in_ready only high in IDLE.
// Build option: VEC_ALU_SATURATE_EN (saturating ADD/SUB, see vec_elem_alu).
module vec_alu_seq
    import vmips_alu_pkg::*;
#(
    parameter int DATA_W     = VEC_W,
    parameter int MIN_ELEM_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_ctrl,
    input  logic [1:0]        df,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              err
);

    localparam int MAX_ELEM = DATA_W / MIN_ELEM_W;
    localparam int CNT_W    = $clog2(MAX_ELEM);
    localparam int SH_W     = $clog2(DATA_W);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        df_q, df_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;

    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] emask, ea, eb, ey, merged;
    logic              eovf, last;

    // Select the current element: bit offset, operand slices and merged result.
    always_comb begin
        case (df_q)
            DF_B:    sh = SH_W'(cnt_q) << 3;
            DF_H:    sh = SH_W'(cnt_q) << 4;
            default: sh = '0;
        endcase
        emask  = DATA_W'(elem_mask(df_q));
        ea     = a_q >> sh;
        eb     = b_q >> sh;
        merged = (result_q & ~(emask << sh)) | ((ey & emask) << sh);
        last   = (3'(cnt_q) == (n_elem(df_q) - 3'd1));
    end

    vec_elem_alu #(.W(DATA_W)) u_elem (
        .op  (op_q),
        .w   (df_q),
        .a   (ea),
        .b   (eb),
        .y   (ey),
        .ovf (eovf)
    );

    // Next-state and datapath control for IDLE -> EXEC -> DONE sequencing.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        df_d     = df_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = alu_ctrl;
                    df_d     = df;
                    a_d      = src_a;
                    b_d      = src_b;
                    cnt_d    = '0;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    if (df == DF_RSV) begin
                        err_d   = 1'b1;
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        zero_d  = 1'b0;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = merged;
                ovf_d    = ovf_q | eovf;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    zero_d  = (merged == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            df_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            df_q     <= df_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: doc/vec_alu_seq.md
Name: vec_alu_seq

Overview:
- Element-serial SIMD ALU. It sits on the consuming side of the 3-bit ALU-control code produced by the ALU-control decoder.
- Accepts one op code, a data-format select and two 32-bit vector operands via valid/ready.
- Executes one element per cycle (byte, halfword or word lanes) and returns the 32-bit vector result with flags via valid/ready.
- Placed in the execute stage of the VMIPS datapath; the stage stalls on in_ready low.

Parameters:
- DATA_W, 32, vector register width in bits.
- MIN_ELEM_W, 8, narrowest element width; sets the maximum element count DATA_W/MIN_ELEM_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- alu_ctrl  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT signed, 101 XOR, 110 NOR, 111 SLTU.
- df  input  2  data format: 00 byte, 01 half, 10 word, 11 reserved.
- src_a  input  DATA_W  operand A vector.
- src_b  input  DATA_W  operand B vector.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  DATA_W  per-element result vector.
- zero  output  1  every result element equals 0.
- ovf  output  1  sticky OR of signed overflow over ADD/SUB elements.
- err  output  1  reserved df was used.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - in_ready=1, out_valid=0, result=0, zero=0, ovf=0, err=0.
  - Element counter and operand registers cleared.
- Reset asserted mid-operation aborts the operation immediately; no partial result is presented.
- Request acceptance: on in_valid&in_ready, capture alu_ctrl, df, src_a and src_b. Set elem_cnt=0 and n_elem = 4 (byte), 2 (half) or 1 (word). Go to EXEC.
- df=11 at acceptance: skip EXEC and go straight to DONE with result=0, err=1, zero=1, ovf=0.
- EXEC:
  - Each cycle, compute element elem_cnt (bits [w*(i+1)-1 : w*i]) and write it into the result register.
  - Element ovf is ORed into the sticky ovf.
  - elem_cnt increments; when elem_cnt==n_elem-1, go to DONE next edge.
  - Input changes during EXEC are ignored (operands are registered).
- DONE:
  - out_valid=1; result, zero, ovf and err are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake, since in_ready is only high in IDLE.
- Latency from the accept edge to out_valid: byte 4 cycles, half 2, word 1, reserved df 1.
- Throughput: one operation per n_elem+2 cycles with out_ready held high.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^w per element. No carry crosses element boundaries.
  - Signed overflow: operand signs equal (ADD) or differ (SUB), and the result sign differs from A.
  - SLT/SLTU: element = 1 if A<B, else 0, zero-extended to w.
  - Logic ops are bitwise within the element. ovf contribution is 0 for non-ADD/SUB ops.
- zero is computed from the final result register when entering DONE.
- out_ready high while in IDLE or EXEC has no effect.

Optional Feature:
- Macro VEC_ALU_SATURATE_EN.
- Defined: ADD/SUB saturate per element to the signed range: 2^(w-1)-1 on positive overflow, -2^(w-1) on negative overflow. ovf still reports that saturation occurred.
- Undefined: wrap-around as specified above; the saturation logic is absent.

Decomposition:
- Package vmips_alu_pkg holds:
  - op code localparams (ALU_ADD..ALU_SLTU);
  - df constants (DF_B, DF_H, DF_W, DF_RSV);
  - state encoding (S_IDLE, S_EXEC, S_DONE);
  - function n_elem(df).
- Sub-module vec_elem_alu: combinational, one 32-bit-wide element operation with width select. Inputs are op, w and the element operands; outputs are the element result and ovf. vec_alu_seq instantiates one copy and muxes element slices into it by elem_cnt.

Test Plan:
- Byte ADD, df=00, A=0x7F01FF10, B=0x01010102 -> after 4 cycles result=0x80020012, ovf=1 (lane3 0x7F+0x01), zero=0.
- Word SUB, df=10, A=5, B=5 -> out_valid 1 cycle after accept, result=0, zero=1, ovf=0.
- Half SLT, df=01, A=0xFFFF0003, B=0x00010002 -> after 2 cycles result=0x00010000.
- Backpressure: out_ready low 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE, next request accepted the following cycle.
- Reserved df=11, any op -> DONE next cycle, err=1, result=0. Reset asserted during byte EXEC cycle 2 -> out_valid=0 and in_ready=1 immediately.
- VEC_ALU_SATURATE_EN defined: byte ADD 0x7F+0x01 -> element 0x7F, ovf=1. Byte SUB 0x80-0x01 -> element 0x80, ovf=1.
